// File: rtl/branch_pkg.sv
// branch_pkg: shared constants and entry type for the branch resolve queue
// Holds the PC width, instruction size used for fall-through redirects,
// and the packed entry recorded for each predicted branch.
package branch_pkg;
  localparam int PC_WIDTH = 16;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                prediction;
  } branch_entry_t;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch push, execute resolve, training and redirect bus
// Ports: push_* (fetch), resolve_* (execute), write_enabled/outcome/pc_bits_write
// (predictor training), mispredict/redirect_pc, empty/full/occupancy, stat_*.
// master drives push/resolve; slave is the queue.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_WIDTH = branch_pkg::PC_WIDTH
);
  logic                    push_valid;
  logic                    push_ready;
  logic [PC_WIDTH-1:0]     push_pc;
  logic                    push_prediction;
  logic                    resolve_valid;
  logic                    resolve_taken;
  logic [PC_WIDTH-1:0]     resolve_target;
  logic                    write_enabled;
  logic                    outcome;
  logic [PC_WIDTH-1:0]     pc_bits_write;
  logic                    mispredict;
  logic [PC_WIDTH-1:0]     redirect_pc;
  logic                    empty;
  logic                    full;
  logic [$clog2(DEPTH):0]  occupancy;
  logic [15:0]             stat_resolved;
  logic [15:0]             stat_mispredicted;
  modport master (
    output push_valid, push_pc, push_prediction, resolve_valid, resolve_taken, resolve_target,
    input  push_ready, write_enabled, outcome, pc_bits_write, mispredict, redirect_pc,
           empty, full, occupancy, stat_resolved, stat_mispredicted
  );
  modport slave (
    input  push_valid, push_pc, push_prediction, resolve_valid, resolve_taken, resolve_target,
    output push_ready, write_enabled, outcome, pc_bits_write, mispredict, redirect_pc,
           empty, full, occupancy, stat_resolved, stat_mispredicted
  );
endinterface

// File: rtl/branch_entry_fifo.sv
// branch_entry_fifo: DEPTH-entry in-order store of predicted branches
// Ports: clk, reset (async active-low), push/pop/flush strobes, push_entry in,
// head_entry out (oldest entry), count (entries held).
// Caller never pushes when full or pops when empty; flush empties the queue
// by moving tail onto the post-pop head.
module branch_entry_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  branch_entry_t          push_entry,
  output branch_entry_t          head_entry,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  branch_entry_t mem [DEPTH];
  logic [AW-1:0] head, tail, head_n, tail_n;
  logic [CW-1:0] count_n;
  always_comb begin
    head_n = head + AW'(pop);
    tail_n = flush ? head_n : tail + AW'(push);
    count_n = flush ? '0 : count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head_n;
      tail <= tail_n;
      count <= count_n;
    end
  always_ff @(posedge clk)
    if (push) mem[tail] <= push_entry;
  assign head_entry = mem[head];
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: records fetch predictions, trains the predictor and redirects on mispredict
// Ports: clk, reset (async active-low), bus (branch_resolve_queue_if.slave).
// Optional macro BRANCH_STATS_EN adds saturating 16-bit resolved/mispredicted
// counters; without it the stat ports are tied to 0.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_WIDTH = branch_pkg::PC_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  branch_resolve_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] occ;
  logic full, empty, push_ok, res_ok, miss;
  logic [PC_WIDTH-1:0] redirect_n;
  branch_entry_t head_entry;
  assign full = occ == CW'(DEPTH);
  assign empty = occ == '0;
  // full is judged before any same-cycle pop; a mispredicting resolve drops the push as wrong-path
  assign push_ok = bus.push_valid && !full;
  assign res_ok = bus.resolve_valid && !empty;
  assign miss = res_ok && (bus.resolve_taken != head_entry.prediction);
  assign redirect_n = bus.resolve_taken ? bus.resolve_target : head_entry.pc + PC_WIDTH'(INSTR_BYTES);
  branch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push_ok && !miss),
    .pop(res_ok),
    .flush(miss),
    .push_entry('{pc: bus.push_pc, prediction: bus.push_prediction}),
    .head_entry(head_entry),
    .count(occ)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.write_enabled <= 1'b0;
      bus.outcome <= 1'b0;
      bus.pc_bits_write <= '0;
      bus.mispredict <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      bus.write_enabled <= res_ok;
      bus.mispredict <= miss;
      if (res_ok) begin
        bus.outcome <= bus.resolve_taken;
        bus.pc_bits_write <= head_entry.pc;
      end
      if (miss) bus.redirect_pc <= redirect_n;
    end
  assign bus.push_ready = !full;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.occupancy = occ;
`ifdef BRANCH_STATS_EN
  logic [15:0] n_res, n_mis;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      n_res <= '0;
      n_mis <= '0;
    end else begin
      n_res <= (res_ok && n_res != '1) ? n_res + 16'd1 : n_res;
      n_mis <= (miss && n_mis != '1) ? n_mis + 16'd1 : n_mis;
    end
  assign bus.stat_resolved = n_res;
  assign bus.stat_mispredicted = n_mis;
`else
  assign bus.stat_resolved = '0;
  assign bus.stat_mispredicted = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed stimulus, queue-based reference model and per-cycle compare
module tb_branch_resolve_queue;
  import branch_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  branch_resolve_queue_if #(.DEPTH(DEPTH)) bus();
  branch_resolve_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  branch_entry_t q[$];
  logic m_we = 0, m_mp = 0, m_out = 0;
  logic [15:0] m_pc = 0, m_redir = 0;
  int m_sr = 0, m_sm = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: a plain queue of recorded predictions
  initial begin
    branch_entry_t e;
    bit can_push, res, miss;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q.delete();
        m_we = 0; m_mp = 0; m_out = 0; m_pc = 0; m_redir = 0; m_sr = 0; m_sm = 0;
      end else begin
        can_push = bus.push_valid && q.size() < DEPTH;
        res = bus.resolve_valid && q.size() > 0;
        miss = 0;
        m_we = res;
        if (res) begin
          e = q.pop_front();
          m_out = bus.resolve_taken;
          m_pc = e.pc;
          miss = bus.resolve_taken != e.prediction;
          if (miss) begin
            q.delete();
            m_redir = bus.resolve_taken ? bus.resolve_target : 16'(e.pc + 16'd4);
          end
`ifdef BRANCH_STATS_EN
          m_sr = m_sr < 65535 ? m_sr + 1 : m_sr;
          if (miss) m_sm = m_sm < 65535 ? m_sm + 1 : m_sm;
`endif
        end
        m_mp = miss;
        if (can_push && !miss) q.push_back('{pc: bus.push_pc, prediction: bus.push_prediction});
      end
    end
  end
  always @(negedge clk) if ($time > 2) begin
    chk("write_enabled", bus.write_enabled, m_we);
    chk("mispredict", bus.mispredict, m_mp);
    chk("occupancy", bus.occupancy, q.size());
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == DEPTH);
    chk("push_ready", bus.push_ready, q.size() != DEPTH);
    chk("stat_resolved", bus.stat_resolved, m_sr);
    chk("stat_mispredicted", bus.stat_mispredicted, m_sm);
    if (m_we) begin
      chk("outcome", bus.outcome, m_out);
      chk("pc_bits_write", bus.pc_bits_write, m_pc);
    end
    if (m_mp) chk("redirect_pc", bus.redirect_pc, m_redir);
  end
  task automatic step(input logic pv, input logic [15:0] pc, input logic pred,
                      input logic rv, input logic rt, input logic [15:0] tgt);
    bus.push_valid = pv;
    bus.push_pc = pc;
    bus.push_prediction = pred;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    bus.resolve_target = tgt;
    @(negedge clk);
  endtask
  task automatic push(input logic [15:0] pc, input logic pred);
    step(1, pc, pred, 0, 0, 0);
  endtask
  task automatic resolve(input logic rt, input logic [15:0] tgt);
    step(0, 0, 0, 1, rt, tgt);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.push_valid = 0; bus.push_pc = 0; bus.push_prediction = 0;
    bus.resolve_valid = 0; bus.resolve_taken = 0; bus.resolve_target = 0;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst empty", bus.empty, 1);
    chk("rst full", bus.full, 0);
    chk("rst occupancy", bus.occupancy, 0);
    chk("rst write_enabled", bus.write_enabled, 0);
    chk("rst redirect_pc", bus.redirect_pc, 0);
    reset = 1'b1;
    // correct prediction trains without redirect
    push(16'h0040, 1);
    resolve(1, 16'h0100);
    chk("t1 write_enabled", bus.write_enabled, 1);
    chk("t1 outcome", bus.outcome, 1);
    chk("t1 pc_bits_write", bus.pc_bits_write, 16'h0040);
    chk("t1 mispredict", bus.mispredict, 0);
    chk("t1 empty", bus.empty, 1);
    // taken mispredict redirects to target, single-cycle pulse
    push(16'h0080, 0);
    resolve(1, 16'h0200);
    chk("t2 mispredict", bus.mispredict, 1);
    chk("t2 redirect_pc", bus.redirect_pc, 16'h0200);
    idle();
    chk("t2 mispredict drop", bus.mispredict, 0);
    chk("t2 write_enabled drop", bus.write_enabled, 0);
    // not-taken mispredict flushes younger entries
    push(16'h0010, 1);
    push(16'h0014, 1);
    push(16'h0018, 1);
    chk("t3 occupancy pre", bus.occupancy, 3);
    resolve(0, 16'h0999);
    chk("t3 redirect_pc", bus.redirect_pc, 16'h0014);
    chk("t3 occupancy", bus.occupancy, 0);
    resolve(1, 16'h0999);
    chk("t3 ignored resolve", bus.write_enabled, 0);
    // full queue refuses pushes, even alongside a pop
    for (int i = 0; i < 4; i++) push(16'(16'h0100 + 4 * i), 1);
    chk("t4 full", bus.full, 1);
    chk("t4 push_ready", bus.push_ready, 0);
    push(16'h0200, 1);
    chk("t4 occupancy refused", bus.occupancy, 4);
    step(1, 16'h0204, 1, 1, 1, 16'h0);
    chk("t4 occupancy pop", bus.occupancy, 3);
    chk("t4 pc_bits_write", bus.pc_bits_write, 16'h0100);
    push(16'h0208, 1);
    chk("t4 occupancy refill", bus.occupancy, 4);
    resolve(1, 0);
    chk("t4 order 1", bus.pc_bits_write, 16'h0104);
    resolve(1, 0);
    chk("t4 order 2", bus.pc_bits_write, 16'h0108);
    resolve(1, 0);
    chk("t4 order 3", bus.pc_bits_write, 16'h010c);
    resolve(1, 0);
    chk("t4 order 4", bus.pc_bits_write, 16'h0208);
    chk("t4 empty", bus.empty, 1);
    // fall-through redirect wraps
    push(16'hFFFC, 1);
    resolve(0, 16'h1234);
    chk("t5 mispredict", bus.mispredict, 1);
    chk("t5 redirect_pc wrap", bus.redirect_pc, 16'h0000);
    idle();
    // asynchronous reset mid-operation
    push(16'h0300, 1);
    push(16'h0304, 0);
    push(16'h0308, 1);
    bus.push_valid = 1; bus.push_pc = 16'h030c; bus.push_prediction = 1;
    bus.resolve_valid = 1; bus.resolve_taken = 0; bus.resolve_target = 16'h0500;
    #2 reset = 1'b0;
    #1;
    chk("t6 empty", bus.empty, 1);
    chk("t6 occupancy", bus.occupancy, 0);
    chk("t6 write_enabled", bus.write_enabled, 0);
    chk("t6 mispredict", bus.mispredict, 0);
    chk("t6 outcome", bus.outcome, 0);
    chk("t6 pc_bits_write", bus.pc_bits_write, 0);
    chk("t6 redirect_pc", bus.redirect_pc, 0);
    chk("t6 stat_resolved", bus.stat_resolved, 0);
    chk("t6 stat_mispredicted", bus.stat_mispredicted, 0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    push(16'h0400, 1);
    push(16'h0404, 1);
    resolve(1, 0);
    resolve(0, 0);
`ifdef BRANCH_STATS_EN
    chk("t6 stats resolved", bus.stat_resolved, 2);
    chk("t6 stats mispredicted", bus.stat_mispredicted, 1);
`else
    chk("t6 stats resolved", bus.stat_resolved, 0);
    chk("t6 stats mispredicted", bus.stat_mispredicted, 0);
`endif
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
